// File: rtl/mod_enc_addroundkey_stream.sv
// mod_enc_addroundkey_stream: streaming AES AddRoundKey with internal key table and 2-entry skid; ADDRK_AUTOROUND_EN selects counter-driven rounds
module mod_enc_addroundkey_stream #(
  parameter int DATA_W   = 128,
  parameter int NUM_RK   = 15,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_wr_en,
  input  logic [RK_IDX_W-1:0] key_wr_idx,
  input  logic [DATA_W-1:0]   key_wr_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [RK_IDX_W-1:0] in_round,
  input  logic                in_first,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [RK_IDX_W-1:0] out_round,
  output logic                out_err
);
  logic [DATA_W-1:0]   key_tbl [NUM_RK];
  logic                live, skid_v, skid_e, rerr, acc, adv, unused;
  logic [DATA_W-1:0]   skid_d, kdat, keyed;
  logic [RK_IDX_W-1:0] skid_r, rsel;
`ifdef ADDRK_AUTOROUND_EN
  logic [RK_IDX_W-1:0] cnt;
  assign rsel   = in_first ? '0 : cnt;
  assign rerr   = 1'b0;
  assign unused = ^in_round;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (acc) cnt <= (rsel == RK_IDX_W'(NUM_RK-1)) ? '0 : rsel + 1'b1;
`else
  assign rsel   = in_round;
  assign rerr   = int'(in_round) >= NUM_RK;
  assign unused = in_first;
`endif
  assign in_ready = !reset && live && !skid_v;
  assign acc      = in_valid && in_ready;
  assign adv      = !out_valid || out_ready;
  assign kdat     = rerr ? '0 : key_tbl[rsel];
  assign keyed    = in_data ^ kdat;
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NUM_RK; i++) key_tbl[i] <= '0;
    else if (key_wr_en && int'(key_wr_idx) < NUM_RK) key_tbl[key_wr_idx] <= key_wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      live      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_err   <= 1'b0;
      skid_v    <= 1'b0;
      skid_d    <= '0;
      skid_r    <= '0;
      skid_e    <= 1'b0;
    end else begin
      live <= 1'b1;
      if (adv) begin
        if (skid_v) begin
          out_valid <= 1'b1;
          out_data  <= skid_d;
          out_round <= skid_r;
          out_err   <= skid_e;
          skid_v    <= 1'b0;
        end else begin
          out_valid <= acc;
          if (acc) begin
            out_data  <= keyed;
            out_round <= rsel;
            out_err   <= rerr;
          end
        end
      end else if (acc) begin
        skid_v <= 1'b1;
        skid_d <= keyed;
        skid_r <= rsel;
        skid_e <= rerr;
      end
    end
endmodule

// File: tb/tb_mod_enc_addroundkey_stream.sv
// tb_mod_enc_addroundkey_stream: queue-based model plus directed literal checks for the AddRoundKey stream stage
module tb_mod_enc_addroundkey_stream;
  localparam int DW = 128, NR = 15, IW = 4;
  logic clk = 0, reset = 1, key_wr_en = 0, in_valid = 0, in_first = 0, out_ready = 1;
  logic [IW-1:0] key_wr_idx = 0, in_round = 0;
  logic [DW-1:0] key_wr_data = 0, in_data = 0;
  logic in_ready, out_valid, out_err;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_round;
  int n_chk = 0, n_fail = 0;

  mod_enc_addroundkey_stream #(.DATA_W(DW), .NUM_RK(NR), .RK_IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_round(in_round), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_round(out_round), .out_err(out_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] kv(input int k);
    logic [7:0] b;
    b = {k[3:0], k[3:0]};
    return k == 0 ? 128'h000102030405060708090a0b0c0d0e0f : {16{b}};
  endfunction

  function automatic logic [DW-1:0] sd(input int r);
    return {4{32'hdeadbeef ^ (32'(r) * 32'h01010101)}};
  endfunction

  typedef struct {logic [DW-1:0] d; logic [IW-1:0] r; logic e;} beat_t;
  beat_t q[$];
  logic [DW-1:0] mk [NR];
  bit live_m = 0;
  int cnt_m = 0;

  always @(negedge clk) begin
    beat_t b;
    int r;
    bit acc, xfer;
    if (reset) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_data", out_data, 0);
      chk("rst_round", out_round, 0);
      chk("rst_err", out_err, 0);
      q.delete();
      foreach (mk[i]) mk[i] = '0;
      live_m = 0;
      cnt_m = 0;
    end else begin
      chk("m_ready", in_ready, live_m && q.size() < 2);
      chk("m_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("m_data", out_data, q[0].d);
        chk("m_round", out_round, q[0].r);
        chk("m_err", out_err, q[0].e);
      end
      xfer = q.size() > 0 && out_ready;
      acc = in_valid && live_m && q.size() < 2;
      if (acc) begin
`ifdef ADDRK_AUTOROUND_EN
        r = in_first ? 0 : cnt_m;
        cnt_m = (r + 1) % NR;
`else
        r = int'(in_round);
`endif
        b.r = IW'(r);
        b.e = r >= NR;
        b.d = b.e ? in_data : in_data ^ mk[r % NR];
      end
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(b);
      if (key_wr_en && int'(key_wr_idx) < NR) mk[key_wr_idx] = key_wr_data;
      live_m = 1;
    end
  end

  task automatic send(input logic [DW-1:0] d, input int r, input bit f);
    int t = 0;
    bit ok = 0;
    in_valid = 1; in_data = d; in_round = IW'(r); in_first = f;
    while (!ok && t < 50) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; t++;
    end
    in_valid = 0; in_first = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    reset = 0;
    @(negedge clk); chk("ready_pre_edge", in_ready, 0);
    @(posedge clk); #1; chk("ready_post_edge", in_ready, 1);
    for (int k = 0; k < NR; k++) begin
      key_wr_en = 1; key_wr_idx = IW'(k); key_wr_data = kv(k); idle(1);
    end
    key_wr_idx = 4'd15; key_wr_data = {16{8'h5a}}; idle(1);
    key_wr_en = 0;
    send(128'h00112233445566778899aabbccddeeff, 0, 1);
    @(negedge clk);
    chk("fips_valid", out_valid, 1);
    chk("fips_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("fips_round", out_round, 0);
    idle(2);
    for (int r = 0; r < NR; r++) begin
      in_valid = 1; in_data = sd(r); in_round = IW'(r); in_first = (r == 0); idle(1);
    end
    in_valid = 0; in_first = 0;
    idle(3);
    out_ready = 0;
    send(sd(100), 1, 0);
    send(sd(101), 2, 0);
    in_valid = 1; in_data = sd(102); in_round = 4'd4;
    repeat (3) begin
      @(negedge clk); chk("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk); chk("bp_head", out_data, sd(100) ^ kv(1));
    @(posedge clk); #1;
    send(sd(102), 4, 0);
    idle(4);
`ifndef ADDRK_AUTOROUND_EN
    key_wr_en = 1; key_wr_idx = 4'd3; key_wr_data = {DW{1'b1}};
    in_valid = 1; in_data = '0; in_round = 4'd3;
    @(negedge clk); chk("rbw_ready", in_ready, 1);
    @(posedge clk); #1;
    key_wr_en = 0; in_valid = 0;
    @(negedge clk); chk("rbw_old", out_data, {16{8'h33}});
    send('0, 3, 0);
    @(negedge clk); chk("rbw_new", out_data, {DW{1'b1}});
    send({16{8'ha5}}, 15, 0);
    @(negedge clk);
    chk("oor_data", out_data, {16{8'ha5}});
    chk("oor_err", out_err, 1);
    send(sd(7), 2, 0);
    @(negedge clk);
    chk("oor_next_err", out_err, 0);
    chk("oor_next_data", out_data, sd(7) ^ kv(2));
    idle(2);
`endif
    out_ready = 0;
    send(sd(200), 5, 0);
    send(sd(201), 6, 0);
    reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    idle(1);
    reset = 0;
    idle(1);
    out_ready = 1;
`ifdef ADDRK_AUTOROUND_EN
    for (int i = 0; i < 4; i++) begin
      send(sd(300 + i), 9, i == 0);
      @(negedge clk);
      chk("auto_round", out_round, IW'(i));
      chk("auto_zero_key", out_data, sd(300 + i));
    end
`else
    send(sd(300), 5, 0);
    @(negedge clk); chk("zero_key5", out_data, sd(300));
    send(sd(301), 0, 0);
    @(negedge clk); chk("zero_key0", out_data, sd(301));
`endif
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
